// File: rtl/sonic_v1_15_pcs_eth_10g_mac_tx_st_stat_collector.sv
// TX Avalon-ST frame snooper: builds one statistics record per frame and queues it.
// Optional pause-frame detection is built when SONIC_TX_STAT_PAUSE_DETECT_EN is defined.
module sonic_v1_15_pcs_eth_10g_mac_tx_st_stat_collector #(
    parameter int MAX_FRAME_LEN = 1518,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic        in_startofpacket,
    input  logic        in_endofpacket,
    input  logic [2:0]  in_empty,
    input  logic [63:0] in_data,
    input  logic [1:0]  in_error,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [39:0] out_data,
    output logic [6:0]  out_error,
    output logic [15:0] out_drop_count
);
    localparam int          AW       = $clog2(FIFO_DEPTH);
    localparam logic [16:0] MAX_LEN  = 17'(MAX_FRAME_LEN);
    localparam logic [0:0]  IDLE     = 1'b0;
    localparam logic [0:0]  IN_FRAME = 1'b1;

    typedef struct packed {
        logic [15:0] len;
        logic        pause;
        logic        mcast;
        logic        bcast;
        logic [6:0]  err;
    } stat_rec_t;

    function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [3:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {13'b0, b};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    function automatic stat_rec_t mk_rec(input logic [15:0] len, input logic b, input logic m,
                                         input logic p, input logic crc, input logic phy);
        stat_rec_t r;
        r.len   = len;
        r.bcast = b;
        r.mcast = m;
        r.pause = p;
        r.err   = {phy, 2'b00, crc, 1'b0, ({1'b0, len} > MAX_LEN), (len < 16'd64)};
        return r;
    endfunction

    logic [0:0]  state_q;
    logic [15:0] len_q;
    logic        bcast_q, mcast_q, pause_q, pause_now;
    logic [3:0]  beat_bytes;
    logic [15:0] len_sop, len_cont;
    logic        sop_bcast, sop_mcast;
    logic        rec0_vld, rec1_vld;
    stat_rec_t   rec0, rec1;
    logic        unused_data;

    assign unused_data = ^in_data;
    assign beat_bytes  = in_endofpacket ? (4'd8 - {1'b0, in_empty}) : 4'd8;
    assign len_sop     = {12'b0, beat_bytes};
    assign len_cont    = sat_add(len_q, beat_bytes);
    assign sop_bcast   = (in_data[63:16] == 48'hFFFF_FFFF_FFFF);
    assign sop_mcast   = in_data[56] & ~sop_bcast;

`ifdef SONIC_TX_STAT_PAUSE_DETECT_EN
    logic pause_da_q, second_q, etype_pause;
    assign etype_pause = (in_data[31:16] == 16'h8808);
    // A frame closing on its second beat needs the ethertype verdict combinationally.
    assign pause_now   = second_q ? (pause_da_q & etype_pause) : pause_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pause_da_q <= 1'b0;
            pause_q    <= 1'b0;
            second_q   <= 1'b0;
        end else if (in_valid) begin
            if (in_startofpacket) begin
                pause_da_q <= (in_data[63:16] == 48'h0180_C200_0001);
                pause_q    <= 1'b0;
                second_q   <= ~in_endofpacket;
            end else if (state_q == IN_FRAME) begin
                second_q <= 1'b0;
                if (second_q) pause_q <= pause_da_q & etype_pause;
            end
        end
    end
`else
    assign pause_q   = 1'b0;
    assign pause_now = 1'b0;
`endif

    // rec0 is the earlier record; rec1 only exists for an abort beat that also ends the new frame.
    always_comb begin
        rec0_vld = 1'b0;
        rec1_vld = 1'b0;
        rec0     = '0;
        rec1     = '0;
        if (in_valid) begin
            if (in_startofpacket && state_q == IN_FRAME) begin
                rec0_vld = 1'b1;
                rec0     = mk_rec(len_q, bcast_q, mcast_q, pause_q, 1'b0, 1'b1);
                rec1_vld = in_endofpacket;
                rec1     = mk_rec(len_sop, sop_bcast, sop_mcast, 1'b0, in_error[1], in_error[0]);
            end else if (in_startofpacket) begin
                rec0_vld = in_endofpacket;
                rec0     = mk_rec(len_sop, sop_bcast, sop_mcast, 1'b0, in_error[1], in_error[0]);
            end else if (state_q == IN_FRAME && in_endofpacket) begin
                rec0_vld = 1'b1;
                rec0     = mk_rec(len_cont, bcast_q, mcast_q, pause_now, in_error[1], in_error[0]);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            len_q   <= '0;
            bcast_q <= 1'b0;
            mcast_q <= 1'b0;
        end else if (in_valid) begin
            if (in_startofpacket) begin
                state_q <= in_endofpacket ? IDLE : IN_FRAME;
                len_q   <= len_sop;
                bcast_q <= sop_bcast;
                mcast_q <= sop_mcast;
            end else if (state_q == IN_FRAME) begin
                len_q <= len_cont;
                if (in_endofpacket) state_q <= IDLE;
            end
        end
    end

    // Holding register: an occupied hold is older than anything built this cycle, so it writes first.
    logic      hold_vld_q, wr_vld;
    stat_rec_t hold_q, wr_rec;
    assign wr_vld = hold_vld_q | rec0_vld;
    assign wr_rec = hold_vld_q ? hold_q : rec0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_vld_q <= 1'b0;
            hold_q     <= '0;
        end else if (hold_vld_q) begin
            hold_vld_q <= rec0_vld;
            hold_q     <= rec0;
        end else begin
            hold_vld_q <= rec1_vld;
            hold_q     <= rec1;
        end
    end

    stat_rec_t   mem [FIFO_DEPTH];
    stat_rec_t   head;
    logic [AW:0] wr_ptr, rd_ptr;
    logic        full, pop, fifo_wr, drop;

    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop     = out_valid & out_ready;
    assign fifo_wr = wr_vld & (~full | pop);
    assign drop    = wr_vld & full & ~pop;
    assign head    = mem[rd_ptr[AW-1:0]];

    assign out_valid = (wr_ptr != rd_ptr);
    assign out_data  = out_valid ? {21'b0, head.pause, head.mcast, head.bcast, head.len} : 40'b0;
    assign out_error = out_valid ? head.err : 7'b0;

    always_ff @(posedge clk) begin
        if (fifo_wr) mem[wr_ptr[AW-1:0]] <= wr_rec;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            out_drop_count <= '0;
        end else begin
            if (fifo_wr) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)     rd_ptr <= rd_ptr + (AW+1)'(1);
            if (drop && out_drop_count != 16'hFFFF) out_drop_count <= out_drop_count + 16'd1;
        end
    end
endmodule

// File: tb/tb_sonic_v1_15_pcs_eth_10g_mac_tx_st_stat_collector.sv
// Directed bench for the TX statistics collector (default parameters).
module tb_sonic_v1_15_pcs_eth_10g_mac_tx_st_stat_collector;
    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_startofpacket, in_endofpacket;
    logic [2:0]  in_empty;
    logic [63:0] in_data;
    logic [1:0]  in_error;
    logic        out_valid, out_ready;
    logic [39:0] out_data;
    logic [6:0]  out_error;
    logic [15:0] out_drop_count;

    int n_tests = 0;
    int n_fail  = 0;

    sonic_v1_15_pcs_eth_10g_mac_tx_st_stat_collector dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_startofpacket(in_startofpacket),
        .in_endofpacket(in_endofpacket), .in_empty(in_empty), .in_data(in_data),
        .in_error(in_error), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_error(out_error), .out_drop_count(out_drop_count)
    );

    always #5 clk = ~clk;

`ifdef SONIC_TX_STAT_PAUSE_DETECT_EN
    localparam logic PAUSE_EXP = 1'b1;
`else
    localparam logic PAUSE_EXP = 1'b0;
`endif

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [39:0] rec(input logic [15:0] len, input logic b, input logic m,
                                        input logic p);
        return {21'b0, p, m, b, len};
    endfunction

    task automatic beat(input logic s, input logic e, input logic [2:0] emp,
                        input logic [63:0] d, input logic [1:0] er);
        @(negedge clk);
        in_valid = 1'b1; in_startofpacket = s; in_endofpacket = e;
        in_empty = emp; in_data = d; in_error = er;
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0; in_startofpacket = 1'b0; in_endofpacket = 1'b0;
        in_empty = 3'd0; in_data = '0; in_error = 2'b00;
    endtask

    // Non-closing beats carry in_error=2'b11 as noise that must not reach the record.
    task automatic send_frame(input int nbytes, input logic [47:0] da, input logic [15:0] etype,
                              input logic [1:0] err);
        int nb;
        logic [63:0] d;
        nb = (nbytes + 7) / 8;
        for (int i = 0; i < nb; i++) begin
            d = 64'h0;
            if (i == 0) d = {da, 16'h0000};
            if (i == 1) d = {32'h0, etype, 16'h0000};
            beat(i == 0, i == nb - 1, (i == nb - 1) ? 3'(nb * 8 - nbytes) : 3'd0, d,
                 (i == nb - 1) ? err : 2'b11);
        end
    endtask

    task automatic pop_rec(input string tag, input logic [39:0] exp_d, input logic [6:0] exp_e);
        int t;
        t = 0;
        while (!out_valid && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk({tag, "_valid"}, 64'(out_valid), 64'd1);
        chk({tag, "_data"}, 64'(out_data), 64'(exp_d));
        chk({tag, "_err"}, 64'(out_error), 64'(exp_e));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b1; out_ready = 1'b0;
        in_valid = 1'b0; in_startofpacket = 1'b0; in_endofpacket = 1'b0;
        in_empty = 3'd0; in_data = '0; in_error = 2'b00;
        repeat (3) @(negedge clk);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_data", 64'(out_data), 64'd0);
        chk("rst_err", 64'(out_error), 64'd0);
        chk("rst_drop", 64'(out_drop_count), 64'd0);
        reset = 1'b0;

        // 64-byte broadcast: valid on the cycle after eop
        send_frame(64, 48'hFFFF_FFFF_FFFF, 16'h0800, 2'b00);
        idle();
        chk("bc_latency", 64'(out_valid), 64'd1);
        pop_rec("bc64", rec(16'd64, 1'b1, 1'b0, 1'b0), 7'b0000000);

        send_frame(60, 48'h0100_5E00_0001, 16'h0800, 2'b10);
        idle();
        pop_rec("mc60", rec(16'd60, 1'b0, 1'b1, 1'b0), 7'b0001001);

        send_frame(1519, 48'h0011_2233_4455, 16'h0800, 2'b00);
        idle();
        pop_rec("over1519", rec(16'd1519, 1'b0, 1'b0, 1'b0), 7'b0000010);

        send_frame(1518, 48'h0011_2233_4455, 16'h0800, 2'b01);
        idle();
        pop_rec("max1518", rec(16'd1518, 1'b0, 1'b0, 1'b0), 7'b1000000);

        beat(1'b1, 1'b1, 3'd3, {48'h0200_0000_0001, 16'h0}, 2'b00);
        idle();
        pop_rec("single5", rec(16'd5, 1'b0, 1'b0, 1'b0), 7'b0000001);

        send_frame(64, 48'h0180_C200_0001, 16'h8808, 2'b00);
        idle();
        pop_rec("pause", rec(16'd64, 1'b0, 1'b1, PAUSE_EXP), 7'b0000000);

        // same DA, wrong ethertype
        send_frame(64, 48'h0180_C200_0001, 16'h0800, 2'b00);
        idle();
        pop_rec("nopause", rec(16'd64, 1'b0, 1'b1, 1'b0), 7'b0000000);

        // abort on the 4th beat, second frame 64B broadcast
        beat(1'b1, 1'b0, 3'd0, {48'h0011_2233_4455, 16'h0}, 2'b00);
        beat(1'b0, 1'b0, 3'd0, 64'h0, 2'b00);
        beat(1'b0, 1'b0, 3'd0, 64'h0, 2'b00);
        beat(1'b1, 1'b0, 3'd0, {48'hFFFF_FFFF_FFFF, 16'h0}, 2'b00);
        for (int i = 0; i < 7; i++) beat(1'b0, i == 6, 3'd0, 64'h0, 2'b00);
        idle();
        pop_rec("abort24", rec(16'd24, 1'b0, 1'b0, 1'b0), 7'b1000001);
        pop_rec("after_abort", rec(16'd64, 1'b1, 1'b0, 1'b0), 7'b0000000);

        // abort beat that is also a single-beat frame: two records, abort first
        beat(1'b1, 1'b0, 3'd0, {48'h0011_2233_4455, 16'h0}, 2'b00);
        beat(1'b0, 1'b0, 3'd0, 64'h0, 2'b00);
        beat(1'b1, 1'b1, 3'd0, {48'h0011_2233_4466, 16'h0}, 2'b10);
        idle();
        pop_rec("abort16", rec(16'd16, 1'b0, 1'b0, 1'b0), 7'b1000001);
        pop_rec("abort_new8", rec(16'd8, 1'b0, 1'b0, 1'b0), 7'b0001001);

        // non-sop beat in IDLE is ignored
        beat(1'b0, 1'b1, 3'd0, 64'h0, 2'b00);
        idle();
        @(negedge clk);
        chk("idle_ignore", 64'(out_valid), 64'd0);

        // overflow: 6 back-to-back records of length 1..6 into a 4-deep FIFO
        for (int k = 1; k <= 6; k++) beat(1'b1, 1'b1, 3'(8 - k), 64'h0, 2'b00);
        idle();
        chk("drop_cnt", 64'(out_drop_count), 64'd2);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("drain%0d_valid", i), 64'(out_valid), 64'd1);
            chk($sformatf("drain%0d_data", i), 64'(out_data),
                64'(rec(16'(i + 1), 1'b0, 1'b0, 1'b0)));
            @(negedge clk);
        end
        chk("drain_empty", 64'(out_valid), 64'd0);
        out_ready = 1'b0;

        // reset mid-frame discards the partial frame and the drop count
        beat(1'b1, 1'b0, 3'd0, {48'hFFFF_FFFF_FFFF, 16'h0}, 2'b00);
        beat(1'b0, 1'b0, 3'd0, 64'h0, 2'b00);
        idle();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midrst_drop", 64'(out_drop_count), 64'd0);
        beat(1'b0, 1'b1, 3'd0, 64'h0, 2'b00);
        idle();
        @(negedge clk);
        chk("midrst_valid", 64'(out_valid), 64'd0);
        send_frame(64, 48'hFFFF_FFFF_FFFF, 16'h0800, 2'b00);
        idle();
        pop_rec("post_rst", rec(16'd64, 1'b1, 1'b0, 1'b0), 7'b0000000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
